// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the candle/match game blocks.
//   state_t        - move sequencer states
//   pos_width()    - bit width of a match position for a given LED count
//   DEF_N_POS      - default number of match positions / LEDs
//   DEF_CANDLE_POS - default candle position
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned DEF_N_POS      = 8;
  localparam int unsigned DEF_CANDLE_POS = 7;

  function automatic int unsigned pos_width(input int unsigned n_pos);
    return (n_pos > 1) ? $clog2(n_pos) : 1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: animation step divider. Counts 0..STEP_DIV-1 while enabled and
// pulses tick on the cycle it wraps.
//   clk  - clock
//   rstn - synchronous active-low reset
//   clr  - synchronous clear (restarts the step period)
//   en   - count enable
//   tick - high for the final cycle of each STEP_DIV-cycle period
module step_timer #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned  CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/match_move_ctrl.sv
// match_move_ctrl: move sequencer for the candle/match game. Accepts a signed
// move, clamps the target to the LED range, walks the match one position per
// STEP_DIV cycles, then counts the move and checks for extinguish/game-over.
//   CLK100MHZ  - clock
//   CPU_RESETN - synchronous active-low reset
//   move_valid - move request
//   move_step  - signed step, -8..+7
//   move_ready - controller can accept a move
//   match_pos  - current match position
//   LED        - one-hot of match_pos
//   busy       - move in progress
//   clamped    - one-cycle pulse when an accepted target was clamped
//   moves_used - accepted-move count (saturates at 15)
//   extinguish - candle out (held until reset)
//   game_over  - moves exhausted (held until reset)
module match_move_ctrl import game_pkg::*; #(
  parameter int unsigned N_POS      = DEF_N_POS,
  parameter int unsigned CANDLE_POS = DEF_CANDLE_POS,
  parameter int unsigned STEP_DIV   = 4,
  parameter int unsigned MAX_MOVES  = 15
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  input  logic                         move_valid,
  input  logic [3:0]                   move_step,
  output logic                         move_ready,
  output logic [pos_width(N_POS)-1:0]  match_pos,
  output logic [N_POS-1:0]             LED,
  output logic                         busy,
  output logic                         clamped,
  output logic [3:0]                   moves_used,
  output logic                         extinguish,
  output logic                         game_over
);

  localparam int unsigned PW = pos_width(N_POS);
  localparam int unsigned RW = PW + 2;
  localparam logic signed [RW-1:0] RAW_MAX = RW'(N_POS - 1);

  state_t          state, state_nx;
  logic [PW-1:0]   target, tgt_c, pos_step;
  logic signed [RW-1:0] raw;
  logic            raw_low, raw_high, accept, tick;
  logic [3:0]      moves_inc;

  // Signed sum: position is zero-extended, step is sign-extended.
  always_comb begin
    raw      = $signed({2'b00, match_pos}) + RW'($signed(move_step));
    raw_low  = raw[RW-1];
    raw_high = !raw_low && (raw > RAW_MAX);
    if (raw_low)       tgt_c = '0;
    else if (raw_high) tgt_c = PW'(N_POS - 1);
    else               tgt_c = raw[PW-1:0];
  end

  assign accept    = (state == IDLE) && move_valid;
  assign pos_step  = (target > match_pos) ? match_pos + 1'b1 : match_pos - 1'b1;
  assign moves_inc = (moves_used == 4'd15) ? moves_used : moves_used + 1'b1;
  assign LED       = N_POS'(1) << match_pos;

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk  (CLK100MHZ),
    .rstn (CPU_RESETN),
    .clr  (accept),
    .en   (state == STEP),
    .tick (tick)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    move_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        move_ready = 1'b1;
        if (move_valid) state_nx = (tgt_c == match_pos) ? CHECK : STEP;
      end
      STEP: begin
        busy = 1'b1;
        if (tick && (pos_step == target)) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (match_pos == PW'(CANDLE_POS))       state_nx = DONE;
        else if (moves_inc == 4'(MAX_MOVES))    state_nx = DONE;
        else                                    state_nx = IDLE;
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      match_pos  <= '0;
      target     <= '0;
      clamped    <= 1'b0;
      moves_used <= '0;
      extinguish <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      clamped <= 1'b0;
      case (state)
        IDLE: if (move_valid) begin
          target  <= tgt_c;
          clamped <= raw_low || raw_high;
        end
        STEP: if (tick) match_pos <= pos_step;
        CHECK: begin
          moves_used <= moves_inc;
          if (match_pos == PW'(CANDLE_POS))    extinguish <= 1'b1;
          else if (moves_inc == 4'(MAX_MOVES)) game_over  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/match_move_ctrl.md
# match_move_ctrl

Move sequencer for the candle/match game. It accepts signed move requests from the debounced centre button and switch bank, then steps the match one LED position at a time toward the clamped target. It detects the match landing on the candle, counts moves, and locks the game at extinguish or game-over. It sits between the button/switch front end and the LED/extinguish outputs of `top_game`.

## Interface
- `N_POS`, 8: number of match positions / LEDs; positions 0..N_POS-1.
- `CANDLE_POS`, 7: position whose exact landing extinguishes the candle.
- `STEP_DIV`, 4: clock cycles per one-position animation step (≥1; board builds use ~25_000_000).
- `MAX_MOVES`, 15: accepted moves before game-over (1..15).

- `CLK100MHZ`  in  1  system clock; one clock.
- `CPU_RESETN`  in  1  reset, synchronous, active-low.
- `move_valid`  in  1  move request.
- `move_step`  in  4  signed two's-complement step, -8..+7.
- `move_ready`  out  1  controller can accept a move.
- `match_pos`  out  $clog2(N_POS)  current match position.
- `LED`  out  N_POS  one-hot of `match_pos`.
- `busy`  out  1  move in progress.
- `clamped`  out  1  one-cycle pulse when an accepted move's target was clamped.
- `moves_used`  out  4  accepted-move count.
- `extinguish`  out  1  level; candle out.
- `game_over`  out  1  level; moves exhausted without extinguish.

## Operation
- States: IDLE, STEP, CHECK, DONE.
- Reset (CPU_RESETN=0 at an edge): state IDLE, match_pos=0, LED=1, moves_used=0, busy=0, clamped=0, extinguish=0, game_over=0, timer=0. Reset applies mid-move and from DONE.
- IDLE: move_ready=1. Accept on move_valid && move_ready.
  - raw = match_pos + sign-extended move_step, computed signed at $clog2(N_POS)+2 bits.
  - target = clamp(raw, 0, N_POS-1). clamped=1 for one cycle when raw≠target.
  - If target == match_pos, go to CHECK. Otherwise go to STEP with timer=0.
- STEP: busy=1, move_ready=0.
  - Timer counts 0..STEP_DIV-1. On wrap, match_pos moves ±1 toward target.
  - Go to CHECK on the same edge match_pos reaches target.
  - move_valid is ignored. There is no queue.
- CHECK: one cycle, busy=1, moves_used+1 (saturating at 15).
  - If match_pos==CANDLE_POS: set extinguish=1 and go to DONE.
  - Else if new moves_used==MAX_MOVES: set game_over=1 and go to DONE.
  - Else go to IDLE.
  - Passing over CANDLE_POS without landing does not extinguish.
  - A step of 0, or a fully clamped step, still counts as a move.
- DONE: move_ready=0, busy=0. All outputs hold until reset.

## Timing
- Accept at edge t0. Effective distance d = |target − match_pos_at_t0|.
- Position updates land at edges t0+k·STEP_DIV, for k=1..d.
- CHECK occupies the cycle after the final update. For d=0, CHECK is the cycle after t0.
- move_ready is high again (or DONE is entered) after edge t0+d·STEP_DIV+1.
- clamped is high for the cycle after t0 only.
- extinguish, game_over and moves_used update at the CHECK→next edge.
- LED is combinational from registered match_pos.

## Structure
- Package `game_pkg`:
  - state enum (IDLE/STEP/CHECK/DONE);
  - position width function ($clog2(N_POS));
  - default N_POS and CANDLE_POS constants, shared with `top_game`.
- Sub-module `step_timer`: STEP_DIV tick counter with synchronous clear and enable. It is cleared on accept and enabled in STEP.

## Test plan
All scenarios use STEP_DIV=4, N_POS=8, CANDLE_POS=7, MAX_MOVES=15.
- Reset → match_pos=0, LED=8'b0000_0001, move_ready=1, all flags 0.
- From pos 0, step +3 accepted at t0:
  - pos 1/2/3 at t0+4/8/12;
  - move_ready back after t0+13;
  - moves_used=1; LED=8'b0000_1000.
- From pos 0, step −1 (4'b1111):
  - clamped pulses once; pos stays 0;
  - ready after t0+1; moves_used increments.
- From pos 3, step +6:
  - target clamped to 7; pos reaches 7 at t0+16;
  - extinguish=1 and DONE at t0+17; later move_valid is not accepted.
- Step +5 accepted; CPU_RESETN=0 for one cycle at t0+6 (pos=1):
  - all outputs return to reset values next cycle;
  - move_valid held high during STEP before the reset is never accepted.
- 15 consecutive step-0 moves:
  - each returns ready 2 cycles after accept;
  - after the 15th, game_over=1, extinguish=0, move_ready=0.
